// File: rtl/payload_aligner_core.sv
// rtl/payload_aligner_core.sv - strips the 7-byte header from a packet and realigns its payload by 7 lanes
// Optional feature macro: PAYLOAD_ALIGNER_BYTE_ENABLE_EN (drives real output byte enables and zeroes disabled lanes)
module payload_aligner_core (
  input  logic        iClk,
  input  logic        iReset,
  input  logic        iValid,
  input  logic [63:0] iPacket,
  input  logic        iSop,
  input  logic        iEop,
  input  logic [7:0]  iByte_enable,
  output logic [63:0] oPayload,
  output logic        oPayload_valid,
  output logic [55:0] oHeaders,
  output logic        oSop,
  output logic        oEop,
  output logic [7:0]  oByte_enable
);

  // ST_IDLE: waiting for a sop beat; ST_IN_PKT: payload beats expected;
  // ST_FLUSH: one extra output beat carries the last residue byte.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_IN_PKT = 2'd1,
    ST_FLUSH  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  residue, residue_nxt;
  logic        first_pend, first_nxt;
  logic [55:0] hdr_q, hdr_nxt;

  logic        emit;
  logic [63:0] emit_data;
  logic [7:0]  emit_be;
  logic        emit_sop;
  logic        emit_eop;
  logic [7:0]  lane_keep;
  logic [63:0] lane_data;

  // State register; reset discards any packet in flight and cancels a pending flush.
  always_ff @(posedge iClk or negedge iReset) begin
    if (!iReset) begin
      state      <= ST_IDLE;
      residue    <= 8'd0;
      first_pend <= 1'b0;
      hdr_q      <= 56'd0;
    end else begin
      state      <= state_nxt;
      residue    <= residue_nxt;
      first_pend <= first_nxt;
      hdr_q      <= hdr_nxt;
    end
  end

  // Next-state and output-beat decode for the current input beat.
  always_comb begin
    state_nxt   = state;
    residue_nxt = residue;
    first_nxt   = first_pend;
    hdr_nxt     = hdr_q;
    emit        = 1'b0;
    emit_data   = 64'd0;
    emit_be     = 8'd0;
    emit_sop    = 1'b0;
    emit_eop    = 1'b0;
    case (state)
      ST_FLUSH: begin
        // Any beat arriving here is dropped; only the stored last byte goes out.
        emit      = 1'b1;
        emit_data = {residue, 56'd0};
        emit_be   = 8'h80;
        emit_eop  = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        if (iValid) begin
          if (iSop) begin
            // A sop always restarts, abandoning any unfinished packet silently.
            hdr_nxt     = iPacket[63:8];
            residue_nxt = iPacket[7:0];
            if (iEop) begin
              emit      = 1'b1;
              emit_sop  = 1'b1;
              emit_eop  = 1'b1;
              first_nxt = 1'b0;
              state_nxt = ST_IDLE;
              if (iByte_enable[0]) begin
                emit_data = {iPacket[7:0], 56'd0};
                emit_be   = 8'h80;
              end
            end else begin
              first_nxt = 1'b1;
              state_nxt = ST_IN_PKT;
            end
          end else if (state == ST_IN_PKT) begin
            emit        = 1'b1;
            emit_data   = {residue, iPacket[63:8]};
            emit_sop    = first_pend;
            first_nxt   = 1'b0;
            residue_nxt = iPacket[7:0];
            emit_be     = 8'hFF;
            if (iEop) begin
              if (iByte_enable[0]) begin
                // Full last beat leaves one byte behind in the residue.
                state_nxt = ST_FLUSH;
              end else begin
                emit_be   = {1'b1, iByte_enable[7:1]};
                emit_eop  = 1'b1;
                state_nxt = ST_IDLE;
              end
            end
          end
        end
      end
    endcase
  end

`ifdef PAYLOAD_ALIGNER_BYTE_ENABLE_EN
  assign lane_keep = emit_be;
`else
  // Lane enables are not exported in this build, so every lane passes through.
  assign lane_keep = emit_be | 8'hFF;
`endif

  // Zero any byte lane whose enable is clear.
  always_comb begin
    lane_data = 64'd0;
    for (int i = 0; i < 8; i++) begin
      if (lane_keep[7-i]) begin
        lane_data[63-8*i -: 8] = emit_data[63-8*i -: 8];
      end
    end
  end

  // Registered output beat, one cycle after the input beat that produced it.
  always_ff @(posedge iClk or negedge iReset) begin
    if (!iReset) begin
      oPayload       <= 64'd0;
      oPayload_valid <= 1'b0;
      oSop           <= 1'b0;
      oEop           <= 1'b0;
    end else begin
      oPayload_valid <= emit;
      oSop           <= emit_sop;
      oEop           <= emit_eop;
      if (emit) begin
        oPayload <= lane_data;
      end
    end
  end

  assign oHeaders = hdr_q;

`ifdef PAYLOAD_ALIGNER_BYTE_ENABLE_EN
  logic [7:0] be_q;

  // Byte-enable register tracks the payload register.
  always_ff @(posedge iClk or negedge iReset) begin
    if (!iReset) begin
      be_q <= 8'd0;
    end else if (emit) begin
      be_q <= emit_be;
    end
  end

  assign oByte_enable = be_q;
`else
  assign oByte_enable = 8'hFF;
`endif

endmodule

// File: tb/tb_payload_aligner_core.sv
// tb/tb_payload_aligner_core.sv - randomized self-checking bench for payload_aligner_core
module tb_payload_aligner_core;

  logic        iClk = 1'b0;
  logic        iReset;
  logic        iValid;
  logic [63:0] iPacket;
  logic        iSop;
  logic        iEop;
  logic [7:0]  iByte_enable;
  logic [63:0] oPayload;
  logic        oPayload_valid;
  logic [55:0] oHeaders;
  logic        oSop;
  logic        oEop;
  logic [7:0]  oByte_enable;

  payload_aligner_core dut (
    .iClk           (iClk),
    .iReset         (iReset),
    .iValid         (iValid),
    .iPacket        (iPacket),
    .iSop           (iSop),
    .iEop           (iEop),
    .iByte_enable   (iByte_enable),
    .oPayload       (oPayload),
    .oPayload_valid (oPayload_valid),
    .oHeaders       (oHeaders),
    .oSop           (oSop),
    .oEop           (oEop),
    .oByte_enable   (oByte_enable)
  );

  always #5 iClk = ~iClk;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  be;
    logic        sop;
    logic        eop;
    logic [55:0] hdr;
  } beat_t;

  beat_t exp_q[$];
  int    checks   = 0;
  int    failures = 0;
  logic  monitor_on = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected output beats derived from the packet bytes: header is bytes 0..6,
  // payload bytes 7.. are packed eight per output beat starting at lane 0.
  function automatic void push_expect(input logic [7:0] pkt[$]);
    beat_t e;
    int    p;
    int    m;
    p     = pkt.size() - 7;
    e.hdr = {pkt[0], pkt[1], pkt[2], pkt[3], pkt[4], pkt[5], pkt[6]};
    if (p == 0) begin
      e.data = 64'd0;
      e.be   = 8'h00;
      e.sop  = 1'b1;
      e.eop  = 1'b1;
      exp_q.push_back(e);
    end else begin
      for (int k = 0; k < p; k += 8) begin
        m      = (p - k < 8) ? p - k : 8;
        e.data = 64'd0;
        for (int j = 0; j < m; j++) e.data[63-8*j -: 8] = pkt[7+k+j];
        e.be   = 8'(16'hFF00 >> m);
        e.sop  = (k == 0);
        e.eop  = (k + 8 >= p);
        exp_q.push_back(e);
      end
    end
  endfunction

  task automatic drive(input logic v, input logic [63:0] d, input logic s, input logic e, input logic [7:0] be);
    @(negedge iClk);
    iValid       = v;
    iPacket      = d;
    iSop         = s;
    iEop         = e;
    iByte_enable = be;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, {$urandom, $urandom}, 1'b0, 1'b0, 8'hFF);
  endtask

  // Drives a packet as beats; the cycle after a full 8-byte eop beat is left
  // idle, or filled with a junk single-beat packet that must be ignored.
  task automatic send_pkt(input logic [7:0] pkt[$], input bit model, input bit junk_gap);
    int          len;
    int          nb;
    int          n;
    logic [63:0] d;
    logic [7:0]  be;
    len = pkt.size();
    nb  = (len + 7) / 8;
    if (model) push_expect(pkt);
    for (int b = 0; b < nb; b++) begin
      n  = (b == nb - 1) ? len - 8 * b : 8;
      be = 8'(16'hFF00 >> n);
      for (int j = 0; j < 8; j++) d[63-8*j -: 8] = (j < n) ? pkt[8*b+j] : 8'($urandom);
      drive(1'b1, d, b == 0, b == nb - 1, be);
    end
    if (len > 8 && len % 8 == 0) drive(junk_gap, {$urandom, $urandom}, 1'b1, 1'b1, 8'hFF);
  endtask

  // Compare every output beat against the next expected beat.
  beat_t       mon_e;
  logic [63:0] mon_mask;
  always @(negedge iClk) begin
    if (monitor_on && iReset && oPayload_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
`ifdef PAYLOAD_ALIGNER_BYTE_ENABLE_EN
        mon_mask = {64{1'b1}};
        check("byte_enable", {56'd0, oByte_enable}, {56'd0, mon_e.be});
`else
        for (int i = 0; i < 8; i++) mon_mask[63-8*i -: 8] = {8{mon_e.be[7-i]}};
        check("byte_enable", {56'd0, oByte_enable}, 64'hFF);
`endif
        check("payload", oPayload & mon_mask, mon_e.data & mon_mask);
        check("sop", {63'd0, oSop}, {63'd0, mon_e.sop});
        check("eop", {63'd0, oEop}, {63'd0, mon_e.eop});
        check("headers", {8'd0, oHeaders}, {8'd0, mon_e.hdr});
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  logic [7:0] pkt[$];
  beat_t      lit;

  initial begin
    iReset = 1'b0;
    iValid = 1'b0;
    iPacket = 64'd0;
    iSop = 1'b0;
    iEop = 1'b0;
    iByte_enable = 8'hFF;
    repeat (3) @(negedge iClk);
    check("rst_valid", {63'd0, oPayload_valid}, 64'd0);
    check("rst_payload", oPayload, 64'd0);
    check("rst_headers", {8'd0, oHeaders}, 64'd0);
    check("rst_sop_eop", {62'd0, oSop, oEop}, 64'd0);
`ifdef PAYLOAD_ALIGNER_BYTE_ENABLE_EN
    check("rst_be", {56'd0, oByte_enable}, 64'd0);
`endif
    iReset = 1'b1;
    monitor_on = 1'b1;

    // 12-byte packet 00..0B with literal expectation
    pkt = {};
    for (int i = 0; i < 12; i++) pkt.push_back(8'(i));
    lit.data = 64'h0708090A0B000000;
    lit.be   = 8'hF8;
    lit.sop  = 1'b1;
    lit.eop  = 1'b1;
    lit.hdr  = 56'h00010203040506;
    exp_q.push_back(lit);
    send_pkt(pkt, 1'b0, 1'b0);

    // 23-byte, 16-byte (junk beat in the gap), 7-byte header-only, 8-byte single beat
    pkt = {}; for (int i = 0; i < 23; i++) pkt.push_back(8'($urandom)); send_pkt(pkt, 1'b1, 1'b0);
    pkt = {}; for (int i = 0; i < 16; i++) pkt.push_back(8'($urandom)); send_pkt(pkt, 1'b1, 1'b1);
    pkt = {}; for (int i = 0; i < 7; i++)  pkt.push_back(8'($urandom)); send_pkt(pkt, 1'b1, 1'b0);
    pkt = {}; for (int i = 0; i < 8; i++)  pkt.push_back(8'($urandom)); send_pkt(pkt, 1'b1, 1'b0);

    // 100 back-to-back packets with a 5-byte payload
    for (int n = 0; n < 100; n++) begin
      pkt = {};
      for (int i = 0; i < 12; i++) pkt.push_back(8'($urandom));
      send_pkt(pkt, 1'b1, 1'b0);
    end

    // sop mid-packet abandons the earlier packet without output
    drive(1'b1, {$urandom, $urandom}, 1'b1, 1'b0, 8'hFF);
    pkt = {}; for (int i = 0; i < 20; i++) pkt.push_back(8'($urandom)); send_pkt(pkt, 1'b1, 1'b0);

    // reset between beat 0 and beat 1
    drive(1'b1, {$urandom, $urandom}, 1'b1, 1'b0, 8'hFF);
    @(negedge iClk);
    iReset = 1'b0;
    iValid = 1'b0;
    @(negedge iClk);
    check("midrst_valid", {63'd0, oPayload_valid}, 64'd0);
    check("midrst_headers", {8'd0, oHeaders}, 64'd0);
    check("midrst_payload", oPayload, 64'd0);
    iReset = 1'b1;
    drive(1'b1, {$urandom, $urandom}, 1'b0, 1'b1, 8'hF0);
    pkt = {}; for (int i = 0; i < 12; i++) pkt.push_back(8'($urandom)); send_pkt(pkt, 1'b1, 1'b0);

    // random lengths and gaps
    for (int n = 0; n < 60; n++) begin
      pkt = {};
      for (int i = 0; i < int'($urandom_range(7, 45)); i++) pkt.push_back(8'($urandom));
      send_pkt(pkt, 1'b1, 1'($urandom));
      idle(int'($urandom_range(0, 2)));
    end

    idle(4);
    check("drain", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
